hazard_ctrl: RTL and testbench

- Parametrised pipeline hazard controller for the pipelined CPU; successor to the fixed 5-stage control path.
- Keeps a scoreboard of in-flight register writers for stages EX..WB (depth DEPTH).
- Generates stall, branch flush and registered forwarding selects.
- Supports a forwarding on/off mode, a configurable load-result stage, an external freeze, and saturating stall/flush event counters.

---
 rtl/hazard_ctrl_pkg.sv | 28 ++
 rtl/hazard_ctrl_sb_match.sv | 49 ++++
 rtl/hazard_ctrl.sv | 115 +++++++++++
 tb/tb_hazard_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: scoreboard entry
// flags, the forwarding "no source" code and elaboration-time helpers.
package hazard_ctrl_pkg;

    // Forward select that means "take the operand from the ID/EX register".
    localparam int FWD_NONE = 0;

    typedef struct packed {
        logic valid;
        logic regwr;
        logic load;
    } entry_flags_t;

    localparam entry_flags_t ENTRY_EMPTY = '{valid: 1'b0, regwr: 1'b0, load: 1'b0};

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Entry index at whose end a writer's result can be forwarded.
    function automatic int ready_stage(input logic load, input int mem_stage);
        return load ? mem_stage : 1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sb_match.sv
// Youngest-writer search for one ID source operand across the scoreboard,
// returning the hit, its entry index and whether it must stall ID.
module sb_match
    import hazard_ctrl_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter int REG_W     = 5,
    parameter int FWD_EN    = 1,
    parameter int MEM_STAGE = 2,
    parameter int K_W       = clog2(DEPTH + 1)
) (
    input  logic                      id_valid,
    input  logic [REG_W-1:0]          src,
    input  logic                      used,
    input  entry_flags_t [DEPTH:1]    flags,
    input  logic [DEPTH:1][REG_W-1:0] dest,
    output logic                      hit,
    output logic [K_W-1:0]            k,
    output logic                      hazard
);

    logic hit_load;

    always_comb begin
        // NOTE: every output gets a default before any branch, so no latch is inferred.
        hit      = 1'b0;
        k        = '0;
        hit_load = 1'b0;
        hazard   = 1'b0;
        if (id_valid && used && (src != '0)) begin
            // Scan oldest to youngest so the smallest matching index wins.
            for (int i = DEPTH; i >= 1; i--) begin
                if (flags[i].valid && flags[i].regwr && (dest[i] == src)) begin
                    hit      = 1'b1;
                    k        = K_W'(i);
                    hit_load = flags[i].load;
                end
            end
        end
        if (hit) begin
            if (FWD_EN != 0) begin
                hazard = int'(k) < ready_stage(hit_load, MEM_STAGE);
            end else begin
                hazard = int'(k) < DEPTH;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Parametrised pipeline hazard controller: in-flight writer scoreboard,
// stall/flush generation, registered forwarding selects and event counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter int REG_W     = 5,
    parameter int FWD_EN    = 1,
    parameter int MEM_STAGE = 2,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          id_valid,
    input  logic [REG_W-1:0]              id_rs,
    input  logic                          id_rs_used,
    input  logic [REG_W-1:0]              id_rt,
    input  logic                          id_rt_used,
    input  logic [REG_W-1:0]              id_rd,
    input  logic                          id_regwr,
    input  logic                          id_load,
    input  logic                          ex_br_taken,
    input  logic                          ext_stall,
    output logic                          stall,
    output logic                          flush,
    output logic [clog2(DEPTH+1)-1:0]     fwd_a,
    output logic [clog2(DEPTH+1)-1:0]     fwd_b,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              flush_cnt
);

    localparam int K_W = clog2(DEPTH + 1);

    entry_flags_t [DEPTH:1]    flags;
    logic [DEPTH:1][REG_W-1:0] dest;
    entry_flags_t              id_flags;

    logic           hit_a, hit_b;
    logic           haz_a, haz_b;
    logic [K_W-1:0] k_a, k_b;
    logic [K_W-1:0] fwd_a_nxt, fwd_b_nxt;
    logic           issue;

    sb_match #(
        .DEPTH(DEPTH), .REG_W(REG_W), .FWD_EN(FWD_EN), .MEM_STAGE(MEM_STAGE), .K_W(K_W)
    ) u_match_a (
        .id_valid (id_valid),
        .src      (id_rs),
        .used     (id_rs_used),
        .flags    (flags),
        .dest     (dest),
        .hit      (hit_a),
        .k        (k_a),
        .hazard   (haz_a)
    );

    sb_match #(
        .DEPTH(DEPTH), .REG_W(REG_W), .FWD_EN(FWD_EN), .MEM_STAGE(MEM_STAGE), .K_W(K_W)
    ) u_match_b (
        .id_valid (id_valid),
        .src      (id_rt),
        .used     (id_rt_used),
        .flags    (flags),
        .dest     (dest),
        .hit      (hit_b),
        .k        (k_b),
        .hazard   (haz_b)
    );

    // A taken branch squashes ID anyway, so it masks any stall request.
    assign flush    = ex_br_taken & ~ext_stall;
    assign stall    = (haz_a | haz_b) & ~flush;
    assign issue    = id_valid & ~stall & ~flush;
    assign id_flags = '{valid: 1'b1, regwr: id_regwr, load: id_load};

    always_comb begin
        fwd_a_nxt = K_W'(FWD_NONE);
        fwd_b_nxt = K_W'(FWD_NONE);
        // Issuing implies neither operand stalls; the writer is one stage further on in EX.
        if ((FWD_EN != 0) && issue) begin
            if (hit_a && (int'(k_a) < DEPTH)) fwd_a_nxt = k_a + 1'b1;
            if (hit_b && (int'(k_b) < DEPTH)) fwd_b_nxt = k_b + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags     <= '0;
            fwd_a     <= '0;
            fwd_b     <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!ext_stall) begin
            flags[1] <= issue ? id_flags : ENTRY_EMPTY;
            for (int i = 2; i <= DEPTH; i++) begin
                flags[i] <= flags[i-1];
            end
            fwd_a <= fwd_a_nxt;
            fwd_b <= fwd_b_nxt;
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // NOTE: destination fields carry no reset; the valid flag of the same entry gates every use.
    always_ff @(posedge clk) begin
        if (!ext_stall) begin
            dest[1] <= id_rd;
            for (int i = 2; i <= DEPTH; i++) begin
                dest[i] <= dest[i-1];
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: three configurations driven in parallel,
// checked every cycle against an age-based writer model plus literal scenarios.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       id_rs_used = 1'b0, id_rt_used = 1'b0;
    logic       id_regwr = 1'b0, id_load = 1'b0;
    logic       ex_br_taken = 1'b0, ext_stall = 1'b0;

    always #5 clk = ~clk;

    logic        s0, s1, s2, f0, f1, f2;
    logic [1:0]  fa0, fb0, fa1, fb1;
    logic [2:0]  fa2, fb2;
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [1:0]  sc2, fc2;

    hazard_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_regwr(id_regwr),
        .id_load(id_load), .ex_br_taken(ex_br_taken), .ext_stall(ext_stall),
        .stall(s0), .flush(f0), .fwd_a(fa0), .fwd_b(fb0), .stall_cnt(sc0), .flush_cnt(fc0)
    );

    hazard_ctrl #(.FWD_EN(0)) u1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_regwr(id_regwr),
        .id_load(id_load), .ex_br_taken(ex_br_taken), .ext_stall(ext_stall),
        .stall(s1), .flush(f1), .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    hazard_ctrl #(.DEPTH(4), .MEM_STAGE(3), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_regwr(id_regwr),
        .id_load(id_load), .ex_br_taken(ex_br_taken), .ext_stall(ext_stall),
        .stall(s2), .flush(f2), .fwd_a(fa2), .fwd_b(fb2), .stall_cnt(sc2), .flush_cnt(fc2)
    );

    logic        d_stall [3];
    logic        d_flush [3];
    logic [2:0]  d_fa [3];
    logic [2:0]  d_fb [3];
    logic [15:0] d_sc [3];
    logic [15:0] d_fc [3];

    assign d_stall[0] = s0;  assign d_stall[1] = s1;  assign d_stall[2] = s2;
    assign d_flush[0] = f0;  assign d_flush[1] = f1;  assign d_flush[2] = f2;
    assign d_fa[0] = {1'b0, fa0};  assign d_fa[1] = {1'b0, fa1};  assign d_fa[2] = fa2;
    assign d_fb[0] = {1'b0, fb0};  assign d_fb[1] = {1'b0, fb1};  assign d_fb[2] = fb2;
    assign d_sc[0] = sc0;  assign d_sc[1] = sc1;  assign d_sc[2] = {14'd0, sc2};
    assign d_fc[0] = fc0;  assign d_fc[1] = fc1;  assign d_fc[2] = {14'd0, fc2};

    localparam int P_DEPTH [3] = '{3, 3, 4};
    localparam int P_FWD   [3] = '{1, 0, 1};
    localparam int P_MEM   [3] = '{2, 2, 3};
    localparam int P_CMAX  [3] = '{65535, 65535, 3};

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: each register writer is remembered with the unfrozen-cycle count at which it
    // entered EX; its current stage is its age in unfrozen cycles.
    typedef struct {
        bit         v;
        int         t;
        logic [4:0] rd;
        bit         ld;
    } wr_rec_t;

    wr_rec_t rec [3][8];
    int tnow [3];
    int m_fa [3];
    int m_fb [3];
    int m_sc [3];
    int m_fc [3];

    function automatic void youngest(input int i, input logic [4:0] src, input logic used,
                                     output int k, output bit ld);
        k  = 0;
        ld = 1'b0;
        if (!(id_valid && used && src != 5'd0)) return;
        for (int j = 0; j < 8; j++) begin
            int age;
            age = tnow[i] - rec[i][j].t + 1;
            if (rec[i][j].v && rec[i][j].rd == src && age <= P_DEPTH[i] && (k == 0 || age < k)) begin
                k  = age;
                ld = rec[i][j].ld;
            end
        end
    endfunction

    function automatic bit blocks(input int i, input int k, input bit ld);
        if (k == 0) return 1'b0;
        if (P_FWD[i] != 0) return k < (ld ? P_MEM[i] : 1);
        return k < P_DEPTH[i];
    endfunction

    function automatic bit exp_flush();
        return ex_br_taken && !ext_stall;
    endfunction

    function automatic bit exp_stall(input int i);
        int ka, kb;
        bit la, lb;
        youngest(i, id_rs, id_rs_used, ka, la);
        youngest(i, id_rt, id_rt_used, kb, lb);
        return (blocks(i, ka, la) || blocks(i, kb, lb)) && !exp_flush();
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                for (int j = 0; j < 8; j++) rec[i][j].v = 1'b0;
                tnow[i] = 0;
                m_fa[i] = 0;  m_fb[i] = 0;  m_sc[i] = 0;  m_fc[i] = 0;
            end else if (!ext_stall) begin
                int ka, kb;
                bit la, lb, st, fl, go, placed;
                youngest(i, id_rs, id_rs_used, ka, la);
                youngest(i, id_rt, id_rt_used, kb, lb);
                st = exp_stall(i);
                fl = exp_flush();
                go = id_valid && !st && !fl;
                m_fa[i] = (go && P_FWD[i] != 0 && ka != 0 && ka < P_DEPTH[i]) ? ka + 1 : 0;
                m_fb[i] = (go && P_FWD[i] != 0 && kb != 0 && kb < P_DEPTH[i]) ? kb + 1 : 0;
                if (st && m_sc[i] < P_CMAX[i]) m_sc[i]++;
                if (fl && m_fc[i] < P_CMAX[i]) m_fc[i]++;
                tnow[i]++;
                for (int j = 0; j < 8; j++)
                    if (rec[i][j].v && tnow[i] - rec[i][j].t + 1 > P_DEPTH[i]) rec[i][j].v = 1'b0;
                placed = 1'b0;
                if (go && id_regwr) begin
                    for (int j = 0; j < 8; j++) begin
                        if (!placed && !rec[i][j].v) begin
                            rec[i][j].v  = 1'b1;
                            rec[i][j].t  = tnow[i];
                            rec[i][j].rd = id_rd;
                            rec[i][j].ld = id_load;
                            placed = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    always @(posedge clk) model_edge();

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("u%0d.stall", i), 32'(d_stall[i]), 32'(exp_stall(i)));
                check($sformatf("u%0d.flush", i), 32'(d_flush[i]), 32'(exp_flush()));
                check($sformatf("u%0d.fwd_a", i), 32'(d_fa[i]), m_fa[i]);
                check($sformatf("u%0d.fwd_b", i), 32'(d_fb[i]), m_fb[i]);
                check($sformatf("u%0d.stall_cnt", i), 32'(d_sc[i]), m_sc[i]);
                check($sformatf("u%0d.flush_cnt", i), 32'(d_fc[i]), m_fc[i]);
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                         input int rd, input bit wr, input bit ld, input bit br, input bit ext);
        id_valid    = v;
        id_rs       = 5'(rs);
        id_rs_used  = rsu;
        id_rt       = 5'(rt);
        id_rt_used  = rtu;
        id_rd       = 5'(rd);
        id_regwr    = wr;
        id_load     = ld;
        ex_br_taken = br;
        ext_stall   = ext;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        next();
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        next();
        next();
        checking = 1'b1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst stall", 32'(s0), 0);
        check("rst flush", 32'(f0), 0);
        check("rst fwd_a", 32'(fa0), 0);
        check("rst fwd_b", 32'(fb0), 0);
        check("rst stall_cnt", 32'(sc0), 0);
        check("rst flush_cnt", 32'(fc0), 0);
        next();

        // ALU result forwarded back-to-back from MEM
        do_reset();
        drive(1, 1, 1, 2, 1, 3, 1, 0, 0, 0); next();
        drive(1, 3, 1, 1, 1, 4, 1, 0, 0, 0);
        @(negedge clk); check("s1 stall", 32'(s0), 0); next();
        idle();
        @(negedge clk); check("s1 fwd_a", 32'(fa0), 2); next();

        // Load-use: one stall, then forward from WB
        do_reset();
        drive(1, 1, 1, 0, 0, 5, 1, 1, 0, 0); next();
        drive(1, 5, 1, 2, 1, 6, 1, 0, 0, 0);
        @(negedge clk); check("s2 stall c1", 32'(s0), 1); next();
        @(negedge clk); check("s2 stall c2", 32'(s0), 0); next();
        idle();
        @(negedge clk);
        check("s2 fwd_a", 32'(fa0), 3);
        check("s2 stall_cnt", 32'(sc0), 1);
        next();

        // No forwarding: wait until the writer reaches WB
        do_reset();
        drive(1, 1, 1, 2, 1, 3, 1, 0, 0, 0); next();
        drive(1, 1, 1, 3, 1, 7, 1, 0, 0, 0);
        @(negedge clk); check("s3 stall c1", 32'(s1), 1); next();
        @(negedge clk); check("s3 stall c2", 32'(s1), 1); next();
        @(negedge clk); check("s3 stall c3", 32'(s1), 0); next();
        idle();
        @(negedge clk);
        check("s3 fwd_b", 32'(fb1), 0);
        check("s3 stall_cnt", 32'(sc1), 2);
        next();

        // Taken branch over a load-use hazard
        do_reset();
        drive(1, 1, 1, 0, 0, 5, 1, 1, 0, 0); next();
        drive(1, 5, 1, 2, 1, 6, 1, 0, 1, 0);
        @(negedge clk);
        check("s4 flush", 32'(f0), 1);
        check("s4 stall", 32'(s0), 0);
        check("s4 stall nofwd", 32'(s1), 0);
        next();
        drive(1, 6, 1, 0, 1, 8, 1, 0, 0, 0);
        @(negedge clk);
        check("s4 bubble", 32'(s1), 0);
        check("s4 flush_cnt", 32'(fc0), 1);
        check("s4 stall_cnt", 32'(sc0), 0);
        check("s4 fwd_a", 32'(fa0), 0);
        next();

        // External freeze during a load-use stall
        do_reset();
        drive(1, 1, 1, 0, 0, 5, 1, 1, 0, 0); next();
        for (int c = 0; c < 4; c++) begin
            drive(1, 5, 1, 2, 1, 6, 1, 0, 0, 1);
            @(negedge clk);
            check("s5 frozen stall", 32'(s0), 1);
            check("s5 frozen stall_cnt", 32'(sc0), 0);
            check("s5 frozen fwd_a", 32'(fa0), 0);
            next();
        end
        drive(1, 5, 1, 2, 1, 6, 1, 0, 0, 0);
        @(negedge clk); check("s5 stall c1", 32'(s0), 1); next();
        @(negedge clk); check("s5 stall c2", 32'(s0), 0); next();
        idle();
        @(negedge clk);
        check("s5 fwd_a", 32'(fa0), 3);
        check("s5 stall_cnt", 32'(sc0), 1);
        next();

        // Saturating 2-bit counter, then reset in the middle of a stall
        do_reset();
        for (int p = 0; p < 3; p++) begin
            drive(1, 1, 1, 0, 0, 5, 1, 1, 0, 0); next();
            drive(1, 5, 1, 2, 1, 6, 1, 0, 0, 0); next(); next(); next();
        end
        idle();
        @(negedge clk); check("s6 stall_cnt sat", 32'(sc2), 3); next();
        drive(1, 1, 1, 0, 0, 5, 1, 1, 0, 0); next();
        drive(1, 5, 1, 2, 1, 6, 1, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk); check("s6 stall before rst", 32'(s2), 1); next();
        rst_n = 1'b1;
        @(negedge clk);
        check("s6 stall after rst", 32'(s2), 0);
        check("s6 stall_cnt after rst", 32'(sc2), 0);
        check("s6 flush_cnt after rst", 32'(fc2), 0);
        next();

        // Random traffic on a small register set to provoke frequent matches
        for (int n = 0; n < 3000; n++) begin
            rst_n       = ($urandom_range(0, 199) != 0);
            id_valid    = ($urandom_range(0, 9) < 8);
            id_rs       = 5'($urandom_range(0, 3));
            id_rs_used  = ($urandom_range(0, 3) != 0);
            id_rt       = 5'($urandom_range(0, 3));
            id_rt_used  = ($urandom_range(0, 3) != 0);
            id_rd       = 5'($urandom_range(0, 3));
            id_regwr    = ($urandom_range(0, 3) != 0);
            id_load     = id_regwr && ($urandom_range(0, 2) == 0);
            ex_br_taken = ($urandom_range(0, 9) == 0);
            ext_stall   = ($urandom_range(0, 9) == 0);
            next();
        end

        rst_n = 1'b1;
        idle();
        next();
        next();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
